pipelined_register_file: RTL and testbench

Parametrised register file for the pipelined RISC datapath. It is the successor of the fixed 16x32 file.
- Configurable data width and register count.
- Three combinational read ports (A, B, D) and one write port (C).
- A dedicated program-counter register (highest index) with its own load path.
- Optional write-to-read bypass.
- A per-register busy scoreboard so the control unit can detect RAW hazards against in-flight instructions.

---
 rtl/pipelined_register_file.sv | 119 +++++++++++
 tb/tb_pipelined_register_file.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_register_file.sv
// Parametrised register file for the pipelined datapath.
// Provides three combinational read ports (A, B, D) and one write port (C).
// The top index holds the program counter, which has its own load path.
// Optional same-cycle bypass shows each port the value after the next edge.
// A busy scoreboard lets the control unit detect RAW hazards.
module pipelined_register_file #(
    parameter int                 DATA_W   = 32,
    parameter int                 NREGS    = 16,
    localparam int                ADDR_W   = $clog2(NREGS),
    parameter logic [DATA_W-1:0]  PC_RESET = '0,
    parameter bit                 BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic [ADDR_W-1:0] SD,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic [DATA_W-1:0] PD,
    input  logic [ADDR_W-1:0] C,
    input  logic [DATA_W-1:0] PW,
    input  logic              RFLd,
    input  logic [DATA_W-1:0] PCin,
    input  logic              PCLd,
    output logic [DATA_W-1:0] PCout,
    input  logic              ISSUE_EN,
    input  logic [ADDR_W-1:0] ISSUE_RD,
    output logic [NREGS-1:0]  BUSY,
    output logic              HAZ_A,
    output logic              HAZ_B,
    output logic              HAZ_D
);

    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    logic [ADDR_W-1:0] sel     [3];
    logic [DATA_W-1:0] rd_data [3];
    logic [2:0]        haz;

    // The bypass is gated by reset so that ports show the reset contents while reset is held.
    logic              fwd_en;

    assign fwd_en = BYPASS && RST_N;

    assign sel[0] = SA;
    assign sel[1] = SB;
    assign sel[2] = SD;

    // Next-state for the array: write-back first, then PC load unless write-back targets the PC.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (RFLd) begin
            regs_d[C] = PW;
        end
        if (PCLd && !(RFLd && (C == PC_IDX))) begin
            regs_d[PC_IDX] = PCin;
        end
    end

    // Scoreboard next-state: retire clears, then a new issue sets (issue wins on the same register).
    always_comb begin
        busy_d = busy_q;
        if (RFLd) begin
            busy_d[C] = 1'b0;
        end
        if (ISSUE_EN) begin
            busy_d[ISSUE_RD] = 1'b1;
        end
    end

    // Read ports and hazard flags, with optional forwarding of this cycle's write.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = regs_q[sel[p]];
            haz[p]     = busy_q[sel[p]];
            if (fwd_en) begin
                if (RFLd && (C == sel[p])) begin
                    rd_data[p] = PW;
                    haz[p]     = 1'b0;
                end else if (PCLd && (sel[p] == PC_IDX)) begin
                    rd_data[p] = PCin;
                end
            end
        end
    end

    assign PA    = rd_data[0];
    assign PB    = rd_data[1];
    assign PD    = rd_data[2];
    assign HAZ_A = haz[0];
    assign HAZ_B = haz[1];
    assign HAZ_D = haz[2];
    assign PCout = regs_q[PC_IDX];
    assign BUSY  = busy_q;

    // State registers; reset clears the array and scoreboard and loads the PC reset value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == NREGS - 1) ? PC_RESET : '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed testbench: one forwarding instance and one non-forwarding instance share stimulus.
module tb_pipelined_register_file;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  SA, SB, SD, C, ISSUE_RD;
    logic [31:0] PW, PCin;
    logic        RFLd, PCLd, ISSUE_EN;

    logic [31:0] PA, PB, PD, PCout;
    logic [15:0] BUSY;
    logic        HAZ_A, HAZ_B, HAZ_D;

    logic [31:0] nb_PA, nb_PB, nb_PD, nb_PCout;
    logic [15:0] nb_BUSY;
    logic        nb_HAZ_A, nb_HAZ_B, nb_HAZ_D;

    int n_pass  = 0;
    int n_total = 0;

    pipelined_register_file #(.DATA_W(32), .NREGS(16), .PC_RESET(32'h100), .BYPASS(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .SA(SA), .SB(SB), .SD(SD),
        .PA(PA), .PB(PB), .PD(PD), .C(C), .PW(PW), .RFLd(RFLd),
        .PCin(PCin), .PCLd(PCLd), .PCout(PCout),
        .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD), .BUSY(BUSY),
        .HAZ_A(HAZ_A), .HAZ_B(HAZ_B), .HAZ_D(HAZ_D)
    );

    pipelined_register_file #(.DATA_W(32), .NREGS(16), .PC_RESET(32'h100), .BYPASS(1'b0)) dut_nb (
        .CLK(CLK), .RST_N(RST_N), .SA(SA), .SB(SB), .SD(SD),
        .PA(nb_PA), .PB(nb_PB), .PD(nb_PD), .C(C), .PW(PW), .RFLd(RFLd),
        .PCin(PCin), .PCLd(PCLd), .PCout(nb_PCout),
        .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD), .BUSY(nb_BUSY),
        .HAZ_A(nb_HAZ_A), .HAZ_B(nb_HAZ_B), .HAZ_D(nb_HAZ_D)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b1; SA = '0; SB = '0; SD = '0; C = '0; PW = '0; RFLd = 1'b0;
        PCin = '0; PCLd = 1'b0; ISSUE_EN = 1'b0; ISSUE_RD = '0;

        // 1. asynchronous reset mid-cycle
        #3;
        RST_N = 1'b0;
        #1;
        chk("rst_pcout_async", PCout, 32'h100);
        chk("rst_pa", PA, 32'h0);
        chk("rst_pb", PB, 32'h0);
        chk("rst_pd", PD, 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_haz", 32'({HAZ_A, HAZ_B, HAZ_D}), 32'h0);
        tick();
        #3;
        RST_N = 1'b1;
        tick();
        tick();
        chk("idle_pcout", PCout, 32'h100);
        chk("idle_busy", 32'(BUSY), 32'h0);
        chk("idle_pa", PA, 32'h0);

        // 2. write and read back every general register
        for (int r = 0; r < 15; r++) begin
            RFLd = 1'b1; C = 4'(r); PW = 32'(r * 3 + 1);
            tick();
            RFLd = 1'b0; SA = 4'(r); SB = 4'(r); SD = 4'(r);
            #1;
            chk("wr_pa", PA, 32'(r * 3 + 1));
            chk("wr_pb", PB, 32'(r * 3 + 1));
            chk("wr_pd", PD, 32'(r * 3 + 1));
            if (r > 0) begin
                SA = 4'(r - 1);
                #1;
                chk("wr_prev_unchanged", PA, 32'(r * 3 - 2));
            end
        end
        for (int r = 0; r < 15; r++) begin
            SD = 4'(r);
            #1;
            chk("readback_all", PD, 32'(r * 3 + 1));
            chk("readback_all_nb", nb_PD, 32'(r * 3 + 1));
        end
        chk("pc_untouched", PCout, 32'h100);

        // 3. PC priority: write-back beats PC load
        PCLd = 1'b1; PCin = 32'h104; RFLd = 1'b1; C = 4'd15; PW = 32'h200; SA = 4'd15;
        #1;
        chk("pc_not_bypassed", PCout, 32'h100);
        chk("pc_bypass_wb", PA, 32'h200);
        chk("pc_nb_read", nb_PA, 32'h100);
        tick();
        chk("pc_wb_wins", PCout, 32'h200);
        PCLd = 1'b1; PCin = 32'h204; RFLd = 1'b0;
        #1;
        chk("pc_bypass_pcin", PA, 32'h204);
        chk("pc_hold_before", PCout, 32'h200);
        tick();
        PCLd = 1'b0;
        #1;
        chk("pc_loaded", PCout, 32'h204);
        chk("pc_nb_loaded", nb_PCout, 32'h204);
        tick();
        chk("pc_holds", PCout, 32'h204);
        chk("pcld_no_busy", 32'(BUSY), 32'h0);

        // 4. bypass versus stored value
        RFLd = 1'b1; C = 4'd5; PW = 32'd7;
        tick();
        PW = 32'd9; SA = 4'd5;
        #1;
        chk("byp_before", PA, 32'd9);
        chk("nobyp_before", nb_PA, 32'd7);
        tick();
        RFLd = 1'b0;
        #1;
        chk("byp_after", PA, 32'd9);
        chk("nobyp_after", nb_PA, 32'd9);

        // 5. scoreboard
        ISSUE_EN = 1'b1; ISSUE_RD = 4'd3;
        tick();
        ISSUE_EN = 1'b0; SB = 4'd3; SA = 4'd4; SD = 4'd3;
        #1;
        chk("sb_busy3", 32'(BUSY), 32'h0008);
        chk("sb_haz_b", 32'(HAZ_B), 32'h1);
        chk("sb_haz_d", 32'(HAZ_D), 32'h1);
        chk("sb_haz_a_clear", 32'(HAZ_A), 32'h0);
        RFLd = 1'b1; C = 4'd3; PW = 32'h33;
        #1;
        chk("sb_haz_masked", 32'(HAZ_B), 32'h0);
        chk("sb_haz_nb_unmasked", 32'(nb_HAZ_B), 32'h1);
        chk("sb_fwd_val", PB, 32'h33);
        tick();
        RFLd = 1'b0;
        #1;
        chk("sb_cleared", 32'(BUSY), 32'h0);
        chk("sb_haz_after_clr", 32'(HAZ_B), 32'h0);
        ISSUE_EN = 1'b1; ISSUE_RD = 4'd3;
        tick();
        RFLd = 1'b1; C = 4'd3; PW = 32'h44;
        #1;
        chk("sb_both_masked", 32'(HAZ_B), 32'h0);
        tick();
        ISSUE_EN = 1'b0; RFLd = 1'b0;
        #1;
        chk("sb_set_wins", 32'(BUSY), 32'h0008);
        chk("sb_reg3_written", PB, 32'h44);
        RFLd = 1'b1; C = 4'd7; PW = 32'h77;
        tick();
        RFLd = 1'b0;
        #1;
        chk("sb_wr_nonbusy", 32'(BUSY), 32'h0008);

        // 6. reset mid-operation
        ISSUE_EN = 1'b1; ISSUE_RD = 4'd0; RFLd = 1'b1; C = 4'd2; PW = 32'h55;
        tick();
        ISSUE_EN = 1'b0; RFLd = 1'b0; SA = 4'd2;
        #1;
        chk("pre_rst_busy", 32'(BUSY), 32'h0009);
        chk("pre_rst_reg2", PA, 32'h55);
        #2;
        RFLd = 1'b1; C = 4'd2; PW = 32'hAA; PCLd = 1'b1; PCin = 32'h300;
        ISSUE_EN = 1'b1; ISSUE_RD = 4'd5;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(BUSY), 32'h0);
        chk("mid_rst_reg2", PA, 32'h0);
        chk("mid_rst_pc", PCout, 32'h100);
        chk("mid_rst_haz", 32'({HAZ_A, HAZ_B, HAZ_D}), 32'h0);
        tick();
        chk("rst_edge_ignored_reg2", PA, 32'h0);
        chk("rst_edge_ignored_pc", PCout, 32'h100);
        chk("rst_edge_ignored_busy", 32'(BUSY), 32'h0);
        RFLd = 1'b0; PCLd = 1'b0; ISSUE_EN = 1'b0;
        #3;
        RST_N = 1'b1;
        tick();
        chk("post_rst_reg2", PA, 32'h0);
        chk("post_rst_pc", PCout, 32'h100);
        chk("post_rst_busy", 32'(BUSY), 32'h0);
        SA = 4'd4;
        #1;
        chk("post_rst_reg4", PA, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
